neural_soc_hw_sw_handshake: RTL and testbench
=============================================

Name: neural_soc_hw_sw_handshake

Overview:
- Hardware-side handshake controller between the software control PIO and the neural compute engine.
- Decodes the 2-bit command from software (to_hw_sig) and sequences the start/done exchange with the compute engine.
- Drives the 2-bit status word (to_sw_sig) that feeds the software-readable status PIO input port.
- Sits directly upstream of the status PIO: its to_sw_sig output is that PIO's in_port.

Parameters:
- TIMEOUT_CYCLES, 1000000, cycles allowed in BUSY before the error status (used only when the optional feature is compiled in).
- CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous reset, active-high.
- to_hw_sig  input  2  software command: 00 idle, 01 start, 10 acknowledge, 11 abort.
- compute_done  input  1  single-cycle pulse from the engine when inference completes.
- compute_start  output  1  single-cycle start pulse to the engine.
- compute_abort  output  1  single-cycle abort pulse to the engine.
- to_sw_sig  output  2  status: 00 idle, 01 busy, 10 done, 11 error.

Behaviour:
- One clock domain (clk); reset is asynchronous and active-high; every flop clears on reset assertion.
- Reset values: compute_start=0, compute_abort=0, to_sw_sig=00, state=IDLE, cmd_prev=00, timeout counter=0.
- All outputs are registered. cmd_prev holds the previous cycle's to_hw_sig.
- A start event is to_hw_sig==01 while cmd_prev==00, i.e. a transition from idle to start. Holding 01 does not re-trigger.
- IDLE (to_sw_sig=00):
  - On a start event, go to BUSY.
  - compute_start=1 in the first BUSY cycle only, so the start pulse appears one cycle after the start event.
- BUSY (to_sw_sig=01):
  - On compute_done=1, go to DONE.
  - If compute_done arrives in the same cycle compute_start is high, it is honoured.
- DONE (to_sw_sig=10):
  - Hold until to_hw_sig==10, then go to RELEASE.
  - compute_done pulses while in DONE are ignored.
- RELEASE (to_sw_sig=00):
  - Hold until to_hw_sig==00, then go to IDLE.
  - This guarantees software returns to idle before the next start.
- ERROR (to_sw_sig=11):
  - Hold until to_hw_sig==10 (acknowledge), then go to RELEASE.
- Abort:
  - to_hw_sig==11 in BUSY gives compute_abort=1 for one cycle, then the state goes to RELEASE.
  - 11 in any other state is ignored.
- Commands not listed for the current state are ignored; the state is unchanged.
- to_sw_sig always reflects the state as of the previous edge, giving one cycle of latency from a state change to its visible status.
- Reset asserted mid-operation returns to IDLE immediately, with no pulses emitted.
- Simultaneous abort and compute_done in BUSY: abort wins and the state goes to RELEASE.

Optional Feature:
- Macro: NEURAL_SOC_HS_TIMEOUT_EN.
- Defined:
  - The counter clears on BUSY entry and increments each BUSY cycle.
  - When the count reaches TIMEOUT_CYCLES-1 without compute_done, the next state is ERROR and compute_abort pulses for one cycle.
  - compute_done in that same cycle wins and the state goes to DONE.
- Undefined: no counter logic is built, ERROR is unreachable, and BUSY waits indefinitely.

Decomposition:
- Package neural_soc_hs_pkg holds:
  - state enum: IDLE, BUSY, DONE, RELEASE, ERROR;
  - command constants: CMD_IDLE, CMD_START, CMD_ACK, CMD_ABORT;
  - status constants: ST_IDLE, ST_BUSY, ST_DONE, ST_ERR.
- One sub-module: neural_soc_hs_timeout, the counter with its clear/enable/expired interface, instantiated only under the macro.

Test Plan:
- Reset: hold reset=1 for 3 cycles with to_hw_sig=01 -> to_sw_sig=00 and compute_start=0 throughout; no start after release while 01 stays held.
- Normal cycle:
  - to_hw_sig 00->01 -> compute_start high exactly one cycle and to_sw_sig=01.
  - compute_done pulse -> to_sw_sig=10.
  - to_hw_sig=10 -> to_sw_sig=00.
  - to_hw_sig=00 -> ready; a second start then works.
- Done with no acknowledge: to_hw_sig stays 01 in DONE for 50 cycles -> to_sw_sig stays 10 and there is no new compute_start.
- Abort: to_hw_sig=11 in BUSY -> compute_abort one cycle and to_sw_sig=00. Abort and compute_done in the same cycle -> abort wins.
- Timeout (macro defined, TIMEOUT_CYCLES=16): start with no done -> to_sw_sig=11 after 16 BUSY cycles plus one abort pulse; to_hw_sig=10 then 00 -> IDLE. With compute_done at count 15 -> DONE.
- Reset mid-BUSY: assert reset for 1 cycle -> to_sw_sig=00 asynchronously and no compute_abort pulse.

Source files
------------

// File: rtl/neural_soc_hs_pkg.sv
// Shared types and constants for the neural SoC hardware/software handshake.
// Optional build macro used by the handshake top: NEURAL_SOC_HS_TIMEOUT_EN.
package neural_soc_hs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY,
        DONE,
        RELEASE,
        ERROR
    } hs_state_t;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_ACK   = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    // Maps a controller state to the status code software reads back.
    function automatic logic [1:0] status_of(input hs_state_t s);
        logic [1:0] st;
        st = ST_IDLE;
        case (s)
            BUSY:    st = ST_BUSY;
            DONE:    st = ST_DONE;
            ERROR:   st = ST_ERR;
            default: st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/neural_soc_hw_sw_handshake_timeout.sv
// BUSY watchdog counter for the handshake controller.
// Only instantiated when NEURAL_SOC_HS_TIMEOUT_EN is defined.
module neural_soc_hs_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Count BUSY cycles; clear takes priority so each BUSY visit starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/neural_soc_hw_sw_handshake.sv
// Hardware side of the software/compute-engine start/done handshake.
// Decodes the software command, pulses start/abort to the engine and
// publishes a 2-bit status word that feeds the status PIO input port.
// Optional build macro: NEURAL_SOC_HS_TIMEOUT_EN adds a BUSY watchdog
// that moves to ERROR and aborts the engine after TIMEOUT_CYCLES.
module neural_soc_hw_sw_handshake
    import neural_soc_hs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] to_hw_sig,
    input  logic       compute_done,
    output logic       compute_start,
    output logic       compute_abort,
    output logic [1:0] to_sw_sig
);

    hs_state_t  state;
    hs_state_t  state_next;
    logic [1:0] cmd_prev;
    logic       cmd_hist_valid;
    logic       start_event;
    logic       abort_cmd;
    logic       timeout_expired;
    logic       start_d;
    logic       abort_d;

    // The counter must be able to represent TIMEOUT_CYCLES-1.
    if ((longint'(1) << CNT_W) <= longint'(TIMEOUT_CYCLES)) begin : g_bad_cfg
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    // The first command sampled after reset has no real history behind it,
    // so a start held through reset cannot masquerade as a fresh 00->01 edge.
    assign start_event = cmd_hist_valid && (to_hw_sig == CMD_START) && (cmd_prev == CMD_IDLE);
    assign abort_cmd   = (to_hw_sig == CMD_ABORT);

`ifdef NEURAL_SOC_HS_TIMEOUT_EN
    logic busy_entry;
    logic in_busy;

    assign busy_entry = (state_next == BUSY) && (state != BUSY);
    assign in_busy    = (state == BUSY);

    neural_soc_hs_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (busy_entry),
        .enable (in_busy),
        .expired(timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    // State, command history and registered outputs; status lags state by one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cmd_prev       <= CMD_IDLE;
            cmd_hist_valid <= 1'b0;
            compute_start  <= 1'b0;
            compute_abort  <= 1'b0;
            to_sw_sig      <= ST_IDLE;
        end else begin
            state          <= state_next;
            cmd_prev       <= to_hw_sig;
            cmd_hist_valid <= 1'b1;
            compute_start  <= start_d;
            compute_abort  <= abort_d;
            to_sw_sig      <= status_of(state);
        end
    end

    // Next-state decode; abort beats done, and done beats the watchdog.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_event) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (abort_cmd) begin
                    state_next = RELEASE;
                end else if (compute_done) begin
                    state_next = DONE;
                end else if (timeout_expired) begin
                    state_next = ERROR;
                end
            end
            DONE: begin
                if (to_hw_sig == CMD_ACK) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (to_hw_sig == CMD_IDLE) begin
                    state_next = IDLE;
                end
            end
            ERROR: begin
                if (to_hw_sig == CMD_ACK) begin
                    state_next = RELEASE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pulse decode, registered above so each pulse lands in the cycle after its cause.
    always_comb begin
        start_d = 1'b0;
        abort_d = 1'b0;
        if (state == IDLE) begin
            start_d = start_event;
        end
        if (state == BUSY) begin
            abort_d = abort_cmd || (!compute_done && timeout_expired);
        end
    end

endmodule

// File: tb/tb_neural_soc_hw_sw_handshake.sv
// Directed self-checking bench for neural_soc_hw_sw_handshake.
// The watchdog section runs only when NEURAL_SOC_HS_TIMEOUT_EN is defined.
module tb_neural_soc_hw_sw_handshake;

    logic       clk;
    logic       reset;
    logic [1:0] to_hw_sig;
    logic       compute_done;
    logic       compute_start;
    logic       compute_abort;
    logic [1:0] to_sw_sig;

    int checks;
    int errors;

    neural_soc_hw_sw_handshake #(
        .TIMEOUT_CYCLES(16),
        .CNT_W         (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .to_hw_sig    (to_hw_sig),
        .compute_done (compute_done),
        .compute_start(compute_start),
        .compute_abort(compute_abort),
        .to_sw_sig    (to_sw_sig)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    // Hold inputs for one cycle, then step just past the rising edge.
    task automatic applyStimulus(input logic [1:0] cmd, input logic done);
        to_hw_sig    = cmd;
        compute_done = done;
        @(posedge clk);
        #1;
    endtask

    // Compare status, start and abort against hand-computed values.
    task automatic checkOutput(input string tag, input logic [1:0] exp_sw,
                               input logic exp_start, input logic exp_abort);
        checks++;
        assert ({to_sw_sig, compute_start, compute_abort} === {exp_sw, exp_start, exp_abort})
        else begin
            errors++;
            $error("[TB] FAIL %s: observed sw=%b start=%b abort=%b, expected sw=%b start=%b abort=%b",
                   tag, to_sw_sig, compute_start, compute_abort, exp_sw, exp_start, exp_abort);
        end
    endtask

    // Directed sequence walking every state transition.
    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        to_hw_sig    = 2'b01;
        compute_done = 1'b0;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b01, 1'b0);
            checkOutput("reset_hold", 2'b00, 1'b0, 1'b0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b01, 1'b0);
            checkOutput("post_reset_held_start", 2'b00, 1'b0, 1'b0);
        end

        applyStimulus(2'b00, 1'b0);
        checkOutput("idle", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("start_pulse", 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("busy_status", 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b1);
        checkOutput("done_edge", 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("done_status", 2'b10, 1'b0, 1'b0);

        for (int i = 0; i < 50; i++) begin
            applyStimulus(2'b01, (i == 10) ? 1'b1 : 1'b0);
            checkOutput("done_no_ack", 2'b10, 1'b0, 1'b0);
        end

        applyStimulus(2'b10, 1'b0);
        checkOutput("ack_edge", 2'b10, 1'b0, 1'b0);
        applyStimulus(2'b10, 1'b0);
        checkOutput("release_status", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0);
        checkOutput("back_to_idle", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("second_start", 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("second_busy", 2'b01, 1'b0, 1'b0);

        applyStimulus(2'b11, 1'b0);
        checkOutput("abort_pulse", 2'b01, 1'b0, 1'b1);
        applyStimulus(2'b11, 1'b0);
        checkOutput("abort_release", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0);
        checkOutput("abort_idle", 2'b00, 1'b0, 1'b0);

        applyStimulus(2'b01, 1'b0);
        checkOutput("start_for_race", 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("busy_for_race", 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b1);
        checkOutput("abort_beats_done", 2'b01, 1'b0, 1'b1);
        applyStimulus(2'b11, 1'b0);
        checkOutput("race_release", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0);
        checkOutput("race_idle", 2'b00, 1'b0, 1'b0);

        applyStimulus(2'b01, 1'b0);
        checkOutput("start_for_fast_done", 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b1);
        checkOutput("done_with_start", 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("fast_done_status", 2'b10, 1'b0, 1'b0);
        applyStimulus(2'b10, 1'b0);
        checkOutput("fast_ack", 2'b10, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0);
        checkOutput("fast_release", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0);
        checkOutput("fast_idle", 2'b00, 1'b0, 1'b0);

        applyStimulus(2'b01, 1'b0);
        checkOutput("start_for_reset", 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("busy_for_reset", 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("busy_hold", 2'b01, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("reset_no_abort", 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(2'b01, 1'b0);
        checkOutput("reset_no_restart", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0);
        checkOutput("reset_idle", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("restart_after_reset", 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b11, 1'b0);
        checkOutput("cleanup_abort", 2'b01, 1'b0, 1'b1);
        applyStimulus(2'b00, 1'b0);
        checkOutput("cleanup_idle", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0);
        checkOutput("cleanup_settle", 2'b00, 1'b0, 1'b0);

`ifdef NEURAL_SOC_HS_TIMEOUT_EN
        applyStimulus(2'b01, 1'b0);
        checkOutput("to_start", 2'b00, 1'b1, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(2'b01, 1'b0);
            checkOutput("to_busy", 2'b01, 1'b0, 1'b0);
        end
        applyStimulus(2'b01, 1'b0);
        checkOutput("to_abort_pulse", 2'b01, 1'b0, 1'b1);
        applyStimulus(2'b01, 1'b0);
        checkOutput("to_error", 2'b11, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("to_error_hold", 2'b11, 1'b0, 1'b0);
        applyStimulus(2'b10, 1'b0);
        checkOutput("to_ack", 2'b11, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0);
        checkOutput("to_release", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0);
        checkOutput("to_idle", 2'b00, 1'b0, 1'b0);

        applyStimulus(2'b01, 1'b0);
        checkOutput("late_start", 2'b00, 1'b1, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(2'b01, 1'b0);
            checkOutput("late_busy", 2'b01, 1'b0, 1'b0);
        end
        applyStimulus(2'b01, 1'b1);
        checkOutput("late_done_wins", 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0);
        checkOutput("late_done_status", 2'b10, 1'b0, 1'b0);
        applyStimulus(2'b10, 1'b0);
        checkOutput("late_ack", 2'b10, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0);
        checkOutput("late_release", 2'b00, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
